// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: PC hand-off, instruction-memory read channel and decode hand-off.
// The fetch unit binds the master modport; the surrounding pipeline binds the slave modport.
interface instr_fetch_if #(
  parameter int WORD_SIZE = 32
);
  // PC register side
  logic [WORD_SIZE-1:0] pc_addr;
  logic                 pc_halt;
  logic                 flush;
  logic                 halt_req;

  // Instruction memory side
  logic                 mem_req;
  logic [WORD_SIZE-1:0] mem_addr;
  logic                 mem_ready;
  logic                 mem_rvalid;
  logic [WORD_SIZE-1:0] mem_rdata;

  // Decode side
  logic                 instr_valid;
  logic [WORD_SIZE-1:0] instr;
  logic [WORD_SIZE-1:0] instr_pc;
  logic                 instr_ready;

  modport master (
    input  pc_addr, flush, halt_req,
    input  mem_ready, mem_rvalid, mem_rdata,
    input  instr_ready,
    output pc_halt, mem_req, mem_addr,
    output instr_valid, instr, instr_pc
  );

  modport slave (
    output pc_addr, flush, halt_req,
    output mem_ready, mem_rvalid, mem_rdata,
    output instr_ready,
    input  pc_halt, mem_req, mem_addr,
    input  instr_valid, instr, instr_pc
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: samples the PC, reads one word from instruction memory and
// holds it for decode; the PC is released only on a delivered instruction or a flush.
module instr_fetch_unit #(
  parameter int WORD_SIZE = 32,
  parameter int COUNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  instr_fetch_if.master      bus,
  output logic [COUNT_W-1:0] fetch_count
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    DRAIN
  } state_e;

  state_e               state_q,    state_d;
  logic [WORD_SIZE-1:0] cur_pc_q,   cur_pc_d;
  logic [WORD_SIZE-1:0] instr_q,    instr_d;
  logic [WORD_SIZE-1:0] instr_pc_q, instr_pc_d;
  logic [COUNT_W-1:0]   count_q,    count_d;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cur_pc_q   <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      cur_pc_q   <= cur_pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      count_q    <= count_d;
    end
  end

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    cur_pc_d   = cur_pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    count_d    = count_q;

    unique case (state_q)
      IDLE: begin
        if (!bus.halt_req && !bus.flush) begin
          cur_pc_d = bus.pc_addr;
          state_d  = REQ;
        end
      end

      // An accepted request still owes a response, so a flush here must drain it.
      REQ: begin
        if (bus.flush) begin
          state_d = bus.mem_ready ? DRAIN : IDLE;
        end else if (bus.mem_ready) begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (bus.flush) begin
          state_d = bus.mem_rvalid ? IDLE : DRAIN;
        end else if (bus.mem_rvalid) begin
          instr_d    = bus.mem_rdata;
          instr_pc_d = cur_pc_q;
          state_d    = HOLD;
        end
      end

      // Flush wins over instr_ready: a redirected instruction is never counted.
      HOLD: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else if (bus.instr_ready) begin
          count_d = count_q + COUNT_W'(1);
          state_d = IDLE;
        end
      end

      DRAIN: begin
        if (bus.mem_rvalid) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.mem_req     = (state_q == REQ);
  assign bus.mem_addr    = (state_q == REQ) ? {cur_pc_q[WORD_SIZE-1:2], 2'b00} : '0;
  assign bus.instr_valid = (state_q == HOLD);
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign fetch_count     = count_q;

  // The PC must hold while reset is asserted even if a flush is presented.
  assign bus.pc_halt = !rst_n || !(bus.flush || ((state_q == HOLD) && bus.instr_ready));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a scoreboard queue holds the instruction/PC pairs
// returned by the memory stub and is popped when decode accepts an instruction.
module tb_instr_fetch_unit;

  localparam int WS = 32;
  localparam int CW = 4;

  typedef struct packed {
    logic [WS-1:0] instr;
    logic [WS-1:0] pc;
  } exp_t;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [CW-1:0] fetch_count;

  int            vectors     = 0;
  int            miscompares = 0;
  exp_t          exp_q[$];
  logic [CW-1:0] exp_count   = '0;

  instr_fetch_if #(.WORD_SIZE(WS)) bus ();

  instr_fetch_unit #(
    .WORD_SIZE(WS),
    .COUNT_W  (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // From IDLE: sample pc, optionally stall mem_ready, finish in WAIT (at posedge+3).
  task automatic start_fetch(input logic [WS-1:0] pc, input int stall);
    logic [WS-1:0] aligned;
    aligned       = pc & ~32'h3;
    bus.pc_addr   = pc;
    bus.mem_ready = 1'b0;
    next_cycle();
    for (int i = 0; i < stall; i++) begin
      settle();
      check("stall_req",  bus.mem_req,  1);
      check("stall_addr", bus.mem_addr, aligned);
      check("stall_halt", bus.pc_halt,  1);
      next_cycle();
    end
    bus.mem_ready = 1'b1;
    settle();
    check("req",      bus.mem_req,     1);
    check("req_addr", bus.mem_addr,    aligned);
    check("req_halt", bus.pc_halt,     1);
    check("req_vld",  bus.instr_valid, 0);
    next_cycle();
    bus.mem_ready = 1'b0;
    settle();
    check("wait_req",  bus.mem_req,     0);
    check("wait_vld",  bus.instr_valid, 0);
    check("wait_halt", bus.pc_halt,     1);
  endtask

  // In WAIT: return data one cycle after acceptance, finish in HOLD.
  task automatic respond(input logic [WS-1:0] data, input logic [WS-1:0] pc, input bit push);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = data;
    if (push) exp_q.push_back('{instr: data, pc: pc});
    next_cycle();
    bus.mem_rvalid = 1'b0;
    settle();
    check("hold_vld",   bus.instr_valid, 1);
    check("hold_instr", bus.instr,       data);
    check("hold_pc",    bus.instr_pc,    pc);
  endtask

  // In HOLD: back-pressure for hold_cycles, then accept and compare against the scoreboard.
  task automatic accept(input int hold_cycles);
    exp_t e;
    check("sb_nonempty", exp_q.size() != 0, 1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    bus.instr_ready = 1'b0;
    for (int i = 0; i < hold_cycles; i++) begin
      check("bp_vld",   bus.instr_valid, 1);
      check("bp_instr", bus.instr,       e.instr);
      check("bp_pc",    bus.instr_pc,    e.pc);
      check("bp_halt",  bus.pc_halt,     1);
      check("bp_count", fetch_count,     exp_count);
      next_cycle();
      settle();
    end
    bus.instr_ready = 1'b1;
    #1;
    check("acc_vld",   bus.instr_valid, 1);
    check("acc_instr", bus.instr,       e.instr);
    check("acc_pc",    bus.instr_pc,    e.pc);
    check("acc_halt",  bus.pc_halt,     0);
    exp_count++;
    next_cycle();
    bus.instr_ready = 1'b0;
    settle();
    check("post_vld",   bus.instr_valid, 0);
    check("post_halt",  bus.pc_halt,     1);
    check("post_req",   bus.mem_req,     0);
    check("post_count", fetch_count,     exp_count);
  endtask

  task automatic deliver(input logic [WS-1:0] pc, input logic [WS-1:0] data,
                         input int stall, input int hold_cycles);
    start_fetch(pc, stall);
    respond(data, pc, 1'b1);
    accept(hold_cycles);
  endtask

  initial begin
    bus.pc_addr     = '0;
    bus.flush       = 1'b1;
    bus.halt_req    = 1'b0;
    bus.mem_ready   = 1'b0;
    bus.mem_rvalid  = 1'b0;
    bus.mem_rdata   = '0;
    bus.instr_ready = 1'b0;

    // Reset values, with a flush presented to show pc_halt still holds.
    #3;
    check("rst_req",   bus.mem_req,     0);
    check("rst_addr",  bus.mem_addr,    0);
    check("rst_vld",   bus.instr_valid, 0);
    check("rst_instr", bus.instr,       0);
    check("rst_ipc",   bus.instr_pc,    0);
    check("rst_count", fetch_count,     0);
    check("rst_halt",  bus.pc_halt,     1);

    // Reset asserted mid-WAIT; the late response must be ignored.
    next_cycle();
    bus.flush = 1'b0;
    rst_n     = 1'b1;
    start_fetch(32'h44, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_req",  bus.mem_req,     0);
    check("midrst_vld",  bus.instr_valid, 0);
    check("midrst_halt", bus.pc_halt,     1);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hBAD0BAD0;
    next_cycle();
    bus.mem_rvalid = 1'b0;
    settle();
    check("midrst_instr", bus.instr, 0);

    // Leave reset with halt_req high: no fetch may start.
    bus.halt_req = 1'b1;
    rst_n        = 1'b1;
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      settle();
      check("halt_req",  bus.mem_req,     0);
      check("halt_pc",   bus.pc_halt,     1);
      check("halt_vld",  bus.instr_valid, 0);
    end
    bus.halt_req = 1'b0;

    // First delivery after reset: 3-cycle latency, single pc_halt drop.
    deliver(32'h0, 32'h20080005, 0, 0);

    // Decode back-pressure for 5 cycles.
    deliver(32'h10, 32'h00A00093, 0, 5);

    // Memory stall; low PC bits ignored for mem_addr but kept in instr_pc.
    deliver(32'h43, 32'h12345678, 4, 0);

    // Flush in WAIT, a second flush in DRAIN, then the late response is discarded.
    start_fetch(32'h8, 0);
    bus.flush = 1'b1;
    #1;
    check("wflush_halt", bus.pc_halt, 0);
    next_cycle();
    bus.flush   = 1'b0;
    bus.pc_addr = 32'h100;
    settle();
    check("drain_req", bus.mem_req,     0);
    check("drain_vld", bus.instr_valid, 0);
    bus.flush = 1'b1;
    next_cycle();
    bus.flush = 1'b0;
    settle();
    check("drain2_req", bus.mem_req,     0);
    check("drain2_vld", bus.instr_valid, 0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hDEADBEEF;
    next_cycle();
    bus.mem_rvalid = 1'b0;
    settle();
    check("drained_vld", bus.instr_valid, 0);
    check("drained_req", bus.mem_req,     0);
    deliver(32'h100, 32'h00500113, 0, 0);

    // Flush and instr_ready together in HOLD: dropped, not counted.
    start_fetch(32'h200, 0);
    respond(32'hCAFE0001, 32'h200, 1'b0);
    bus.flush       = 1'b1;
    bus.instr_ready = 1'b1;
    #1;
    check("hflush_halt", bus.pc_halt,     0);
    check("hflush_vld",  bus.instr_valid, 1);
    next_cycle();
    bus.flush       = 1'b0;
    bus.instr_ready = 1'b0;
    settle();
    check("hflush_post_vld",   bus.instr_valid, 0);
    check("hflush_post_count", fetch_count,     exp_count);
    check("hflush_post_halt",  bus.pc_halt,     1);

    // Flush in WAIT coinciding with rvalid: straight back to IDLE, data dropped.
    start_fetch(32'h300, 0);
    bus.flush      = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hFEEDF00D;
    next_cycle();
    bus.flush      = 1'b0;
    bus.mem_rvalid = 1'b0;
    settle();
    check("wrflush_vld", bus.instr_valid, 0);
    check("wrflush_req", bus.mem_req,     0);
    deliver(32'h304, 32'h00000013, 0, 0);

    // Five deliveries so far; eleven more wrap the 4-bit counter to zero.
    for (int i = 0; i < 11; i++) begin
      deliver(32'h400 + 32'(i * 4), $urandom, i % 3, i % 2);
    end
    check("wrap_count", fetch_count,  0);
    check("sb_empty",   exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
